uart_rx_fsm: RTL and testbench

Control state machine for the UART receiver. It detects the start of a frame on the serial line and paces each bit period with internal edge and bit counters. It issues one-cycle enable strobes to the start, data-deserializer, parity and stop checkers, then combines their error flags into a per-frame `data_valid` or error pulse. It sits beside those sub-blocks inside the UART RX top level and is the only block that sequences them.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_edge_bit_cnt.sv | 45 ++++
 rtl/uart_rx_fsm.sv | 131 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int BIT_CNT_W      = 3;

   // Supported oversampling ratios (clocks per bit).
   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Bit-period pacing: edge counter within a bit and data-bit counter.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  bit_inc_i,
   input  logic [PRESCALE_W-1:0] p_i,
   output logic                  last_edge_o,
   output logic                  strobe_edge_o,
   output logic                  last_bit_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;

   assign last_edge_o   = (edge_cnt_q == p_i - PRESCALE_W'(1));
   // One cycle ahead of the strobe point so the registered strobe lands on P-2.
   assign strobe_edge_o = (edge_cnt_q == p_i - PRESCALE_W'(3));
   assign last_bit_o    = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));

   // Edge counter: 0..P-1, wraps on every bit boundary.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i)  edge_cnt_q <= '0;
      else if (en_i) begin
         if (last_edge_o)     edge_cnt_q <= '0;
         else                 edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
      end
   end

   // Data-bit counter: advances at the end of each data bit, wraps after the last.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i)  bit_cnt_q <= '0;
      else if (bit_inc_i) begin
         if (last_bit_o)      bit_cnt_q <= '0;
         else                 bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver sequencer: frame detection, checker strobes, result pulses.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = 6
) (
   input  logic                  uart_rx_fsm_clk,
   input  logic                  uart_rx_fsm_rst,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic                  dat_samp_en,
   output logic                  strt_chk_en,
   output logic                  deser_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  parity_err
);

   rx_state_e             state_q;
   logic [PRESCALE_W-1:0] p_q;
   logic                  par_q, par_err_q;
   logic                  dat_samp_q, strt_chk_q, deser_q, par_chk_q, stp_chk_q;
   logic                  data_valid_q, frame_err_q, parity_err_q;
   logic                  last_edge, strobe_edge, last_bit;

   uart_rx_edge_bit_cnt #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_cnt (
      .clk_i         (uart_rx_fsm_clk),
      .rst_n_i       (uart_rx_fsm_rst),
      .en_i          (state_q != IDLE),
      .clr_i         (state_q == IDLE),
      .bit_inc_i     ((state_q == DATA) && last_edge),
      .p_i           (p_q),
      .last_edge_o   (last_edge),
      .strobe_edge_o (strobe_edge),
      .last_bit_o    (last_bit)
   );

   // State register, frame-start latches and all registered outputs.
   always_ff @(posedge uart_rx_fsm_clk) begin
      if (!uart_rx_fsm_rst) begin
         state_q      <= IDLE;
         p_q          <= PRESCALE_W'(PRESCALE_8);
         par_q        <= 1'b0;
         par_err_q    <= 1'b0;
         dat_samp_q   <= 1'b0;
         strt_chk_q   <= 1'b0;
         deser_q      <= 1'b0;
         par_chk_q    <= 1'b0;
         stp_chk_q    <= 1'b0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         strt_chk_q   <= 1'b0;
         deser_q      <= 1'b0;
         par_chk_q    <= 1'b0;
         stp_chk_q    <= 1'b0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_in) begin
                  state_q    <= START;
                  p_q        <= prescale;
                  par_q      <= par_en;
                  par_err_q  <= 1'b0;
                  dat_samp_q <= 1'b1;
               end
            end
            START: begin
               strt_chk_q <= strobe_edge;
               if (last_edge) begin
                  if (strt_glitch) begin
                     state_q    <= IDLE;
                     dat_samp_q <= 1'b0;
                  end else begin
                     state_q    <= DATA;
                  end
               end
            end
            DATA: begin
               deser_q <= strobe_edge;
               if (last_edge && last_bit) state_q <= par_q ? PARITY : STOP;
            end
            PARITY: begin
               par_chk_q <= strobe_edge;
               if (last_edge) begin
                  par_err_q <= par_err;
                  state_q   <= STOP;
               end
            end
            STOP: begin
               stp_chk_q <= strobe_edge;
               // stp_err is only trusted here; the checker holds a stale flag otherwise.
               if (last_edge) begin
                  data_valid_q <= !stp_err && !par_err_q;
                  frame_err_q  <= stp_err;
                  parity_err_q <= par_err_q;
                  state_q      <= IDLE;
                  dat_samp_q   <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               dat_samp_q <= 1'b0;
            end
         endcase
      end
   end

   assign dat_samp_en = dat_samp_q;
   assign strt_chk_en = strt_chk_q;
   assign deser_en    = deser_q;
   assign par_chk_en  = par_chk_q;
   assign stp_chk_en  = stp_chk_q;
   assign data_valid  = data_valid_q;
   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with simple start/parity/stop checker models.
module tb_uart_rx_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       par_en = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
   logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
   logic       data_valid, frame_err, parity_err;

   // Values the checker models will report for the current frame.
   logic m_glitch = 1'b0, m_par = 1'b0, m_stp = 1'b0;

   int n_cmp = 0, n_fail = 0;
   int cyc = 0;

   uart_rx_fsm dut (
      .uart_rx_fsm_clk (clk),
      .uart_rx_fsm_rst (rst_n),
      .rx_in           (rx_in),
      .par_en          (par_en),
      .prescale        (prescale),
      .strt_glitch     (strt_glitch),
      .par_err         (par_err),
      .stp_err         (stp_err),
      .dat_samp_en     (dat_samp_en),
      .strt_chk_en     (strt_chk_en),
      .deser_en        (deser_en),
      .par_chk_en      (par_chk_en),
      .stp_chk_en      (stp_chk_en),
      .data_valid      (data_valid),
      .frame_err       (frame_err),
      .parity_err      (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Checker models: result valid the cycle after the strobe, held until next strobe.
   always @(posedge clk) begin
      if (strt_chk_en) strt_glitch <= m_glitch;
      if (par_chk_en)  par_err     <= m_par;
      if (stp_chk_en)  stp_err     <= m_stp;
   end

   // Event monitor sampled on the falling edge.
   int   start_cyc = 0, fall_cyc = 0, dv_cyc = 0, fe_cyc = 0, pe_cyc = 0;
   int   strt_cyc = 0, par_cyc = 0;
   int   n_dv = 0, n_fe = 0, n_pe = 0, n_strt = 0, n_par = 0, n_stp = 0, n_deser = 0;
   int   excl_bad = 0;
   logic samp_prev = 1'b0;
   int   deser_q[$];

   always @(negedge clk) begin
      samp_prev <= dat_samp_en;
      if (dat_samp_en === 1'b1 && samp_prev === 1'b0) start_cyc <= cyc;
      if (dat_samp_en === 1'b0 && samp_prev === 1'b1) fall_cyc  <= cyc;
      if (deser_en === 1'b1) begin
         n_deser <= n_deser + 1;
         deser_q.push_back(cyc);
      end
      if (strt_chk_en === 1'b1) begin n_strt <= n_strt + 1; strt_cyc <= cyc; end
      if (par_chk_en === 1'b1)  begin n_par  <= n_par + 1;  par_cyc  <= cyc; end
      if (stp_chk_en === 1'b1)  n_stp <= n_stp + 1;
      if (data_valid === 1'b1)  begin n_dv <= n_dv + 1; dv_cyc <= cyc; end
      if (frame_err === 1'b1)   begin n_fe <= n_fe + 1; fe_cyc <= cyc; end
      if (parity_err === 1'b1)  begin n_pe <= n_pe + 1; pe_cyc <= cyc; end
      if (data_valid === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1))
         excl_bad <= excl_bad + 1;
   end

   int s_dv, s_fe, s_pe, s_strt, s_par, s_stp, s_deser;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      s_dv = n_dv; s_fe = n_fe; s_pe = n_pe; s_strt = n_strt;
      s_par = n_par; s_stp = n_stp; s_deser = n_deser;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_gaps(input string tag, input int b, input int p);
      int ok = 1;
      if (deser_q.size() < b + 8) ok = 0;
      else for (int j = 1; j < 8; j++)
         if (deser_q[b+j] - deser_q[b+j-1] != p) ok = 0;
      check(tag, ok, 1);
   endtask

   // Drives one line frame LSB-first; optionally changes prescale before data bit chg_bit.
   task automatic send_frame(input int p, input logic [7:0] d, input bit has_par,
                             input int chg_bit, input logic [5:0] chg_p);
      rx_in = 1'b0; tick(p);
      for (int i = 0; i < 8; i++) begin
         if (i == chg_bit) prescale = chg_p;
         rx_in = d[i]; tick(p);
      end
      if (has_par) begin rx_in = ^d; tick(p); end
      rx_in = 1'b1; tick(p);
   endtask

   int b;

   initial begin
      // Reset
      rst_n = 1'b0; tick(3);
      check("rst_outputs", {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                            data_valid, frame_err, parity_err}, 0);
      rst_n = 1'b1; tick(2);
      check("idle_samp", dat_samp_en, 0);

      // Good frame, P=8, no parity
      prescale = 6'd8; par_en = 1'b0; snap(); b = deser_q.size();
      send_frame(8, 8'h5A, 0, -1, 6'd0); tick(3);
      check("A_deser_cnt", n_deser - s_deser, 8);
      check_gaps("A_deser_gap", b, 8);
      check("A_first_deser", deser_q[b] - start_cyc, 14);
      check("A_strt_pos", strt_cyc - start_cyc, 6);
      check("A_strt_cnt", n_strt - s_strt, 1);
      check("A_stp_cnt", n_stp - s_stp, 1);
      check("A_par_cnt", n_par - s_par, 0);
      check("A_dv_cnt", n_dv - s_dv, 1);
      check("A_dv_lat", dv_cyc - start_cyc, 80);
      check("A_err_cnt", (n_fe - s_fe) + (n_pe - s_pe), 0);
      check("A_samp_fall", fall_cyc - start_cyc, 80);

      // Parity error, P=16
      prescale = 6'd16; par_en = 1'b1; m_par = 1'b1; snap();
      send_frame(16, 8'hA5, 1, -1, 6'd0); tick(3);
      m_par = 1'b0; par_en = 1'b0;
      check("B_par_cnt", n_par - s_par, 1);
      check("B_par_pos", par_cyc - start_cyc, 158);
      check("B_pe_cnt", n_pe - s_pe, 1);
      check("B_pe_lat", pe_cyc - start_cyc, 176);
      check("B_dv_cnt", n_dv - s_dv, 0);
      check("B_fe_cnt", n_fe - s_fe, 0);

      // Start glitch, P=8
      prescale = 6'd8; m_glitch = 1'b1; snap();
      rx_in = 1'b0; tick(3); rx_in = 1'b1; tick(15);
      m_glitch = 1'b0;
      check("C_deser_cnt", n_deser - s_deser, 0);
      check("C_result_cnt", (n_dv - s_dv) + (n_fe - s_fe) + (n_pe - s_pe), 0);
      check("C_idle_after", fall_cyc - start_cyc, 8);
      check("C_samp_now", dat_samp_en, 0);

      // Stop error then immediate good frame
      m_stp = 1'b1; snap();
      send_frame(8, 8'hC3, 0, -1, 6'd0);
      m_stp = 1'b0;
      send_frame(8, 8'h3C, 0, -1, 6'd0); tick(3);
      check("D_fe_cnt", n_fe - s_fe, 1);
      check("D_dv_cnt", n_dv - s_dv, 1);
      check("D_pe_cnt", n_pe - s_pe, 0);
      check("D_dv_after_fe", dv_cyc - fe_cyc, 81);
      check("D_dv_lat", dv_cyc - start_cyc, 80);

      // Reset during DATA bit 4, then a normal frame
      prescale = 6'd8; snap();
      rx_in = 1'b0; tick(8); rx_in = 1'b1; tick(35);
      rst_n = 1'b0; tick(1);
      check("E_rst_outputs", {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                              data_valid, frame_err, parity_err}, 0);
      check("E_deser_before", n_deser - s_deser, 4);
      rst_n = 1'b1; tick(2);
      check("E_result_cnt", (n_dv - s_dv) + (n_fe - s_fe) + (n_pe - s_pe), 0);
      snap(); b = deser_q.size();
      send_frame(8, 8'h81, 0, -1, 6'd0); tick(3);
      check("E_dv_cnt", n_dv - s_dv, 1);
      check("E_dv_lat", dv_cyc - start_cyc, 80);
      check("E_first_deser", deser_q[b] - start_cyc, 14);

      // Prescale change mid-frame: current frame keeps 8, next uses 32
      prescale = 6'd8; snap(); b = deser_q.size();
      send_frame(8, 8'h5A, 0, 3, 6'd32); tick(3);
      check("F_dv_lat8", dv_cyc - start_cyc, 80);
      check_gaps("F_gap8", b, 8);
      check("F_dv_cnt8", n_dv - s_dv, 1);
      snap(); b = deser_q.size();
      send_frame(32, 8'hF0, 0, -1, 6'd0); tick(3);
      check("F_dv_lat32", dv_cyc - start_cyc, 320);
      check("F_first_deser32", deser_q[b] - start_cyc, 62);
      check_gaps("F_gap32", b, 32);
      check("F_dv_cnt32", n_dv - s_dv, 1);

      check("exclusivity", excl_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
